// File: rtl/ac3_pkg.sv
// Shared AC3 definitions: accumulator width rule and the drain FSM states.
package ac3_pkg;

  // Accumulator width grows with the column count, operand widths and MAC depth.
  function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno);
  endfunction

  // Width for the default configuration (M=16, Pa=8, Pw=4, MNO=288).
  localparam int ACC_W = acc_w(16, 8, 4, 288);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ac3_sat.sv
// Signed saturation of a wide accumulator value to the activation width,
// with optional clamping of negatives to zero.
module ac3_sat #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  i_val,
  input  logic                    i_relu,
  output logic signed [OUT_W-1:0] o_val
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  // Clamp to [MIN_V, MAX_V]; ReLU takes precedence for negative inputs.
  always_comb begin
    // NOTE: output gets a default before the if-chain so no path leaves it unassigned (no latch).
    o_val = i_val[OUT_W-1:0];
    if (i_relu && i_val[IN_W-1]) begin
      o_val = '0;
    end else if (i_val > MAX_V) begin
      o_val = MAX_V[OUT_W-1:0];
    end else if (i_val < MIN_V) begin
      o_val = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/ac3_quant_drain.sv
// AC3 output-register drain engine: captures NREG accumulators, shifts them
// right one bit per cycle for the programmed amount, then streams saturated
// results one per valid/ready handshake and pulses done after the last beat.
module ac3_quant_drain
  import ac3_pkg::*;
#(
  parameter  int M     = 16,
  parameter  int Pa    = 8,
  parameter  int Pw    = 4,
  parameter  int MNO   = 288,
  parameter  int NREG  = 4,
  localparam int ACC_W = acc_w(M, Pa, Pw, MNO),
  localparam int SW    = $clog2(ACC_W),
  localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SW-1:0]          shamt,
  input  logic                   relu_en,
  input  logic [NREG*ACC_W-1:0]  acc_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [Pa-1:0]   out_data,
  output logic [IW-1:0]          out_idx,
  output logic                   done
);

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc [NREG];
  logic [SW-1:0]             r_cnt;
  logic                      r_relu;
  logic [IW-1:0]             r_idx;
  logic                      r_valid;
  logic                      r_busy;
  logic                      r_done;
  logic signed [ACC_W-1:0]   w_sel;

  // Job control: capture on start, shift while counting down, drain on handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      // NOTE: the accumulator array is reset too, so out_data reads 0 straight out of reset.
      for (int k = 0; k < NREG; k++) r_acc[k] <= '0;
      r_cnt   <= '0;
      r_relu  <= 1'b0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NREG; k++) r_acc[k] <= acc_in[k*ACC_W +: ACC_W];
            r_cnt  <= shamt;
            r_relu <= relu_en;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (shamt != '0) begin
              r_state <= SHIFT;
            end else begin
              r_state <= DRAIN;
              r_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Arithmetic shift replicates the sign bit: floor division by two.
          for (int k = 0; k < NREG; k++) r_acc[k] <= r_acc[k] >>> 1;
          r_cnt <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) begin
            r_state <= DRAIN;
            r_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (r_idx == IW'(NREG - 1)) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Single saturator after the register-select mux.
  assign w_sel = r_acc[r_idx];

  ac3_sat #(
    .IN_W  (ACC_W),
    .OUT_W (Pa)
  ) u_sat (
    .i_val  (w_sel),
    .i_relu (r_relu),
    .o_val  (out_data)
  );

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_ac3_quant_drain.sv
// Self-checking bench for ac3_quant_drain: a behavioural model computes each
// beat as saturate(floor(acc / 2^shamt)), a monitor checks every valid beat
// against it, and the job task checks cycle timing and done counts.
module tb_ac3_quant_drain;

  localparam int NREG  = 4;
  localparam int ACC_W = 25;
  localparam int SW    = 5;
  localparam int PA    = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [SW-1:0]         shamt;
  logic                  relu_en;
  logic [NREG*ACC_W-1:0] acc_in;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [PA-1:0]  out_data;
  logic [1:0]            out_idx;
  logic                  done;

  ac3_quant_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .shamt     (shamt),
    .relu_en   (relu_en),
    .acc_in    (acc_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_done   = 0;
  int    n_hs     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor division by 2^sh, then clamp to the activation range.
  function automatic int model(input longint a, input int sh, input bit relu);
    longint v;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (PA - 1)) - 1;
    lo = -hi - 1;
    v  = a >>> sh;
    if (relu && v < 0) return 0;
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  // Monitor: every valid beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_valid, 0);
      end else begin
        check("beat_idx", out_idx, exp_q[0].idx);
        check("beat_data", $signed(out_data), exp_q[0].data);
        if (out_ready) begin
          void'(exp_q.pop_front());
          n_hs++;
        end
      end
    end
    if (done) n_done++;
  end

  function automatic int rand_acc();
    logic [31:0] r;
    int sel;
    sel = $urandom_range(0, 2);
    r   = $urandom;
    case (sel)
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'({{7{r[24]}}, r[24:0]});
      default: return int'($urandom_range(0, 80000)) - 40000;
    endcase
  endfunction

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_job(input int a[NREG], input int sh, input bit relu,
                         input int mode, input bit poke);
    int  done0;
    int  hs0;
    bit  seen;
    beat_t b;
    for (int k = 0; k < NREG; k++) acc_in[k*ACC_W +: ACC_W] = ACC_W'(a[k]);
    shamt   = SW'(sh);
    relu_en = relu;
    start   = 1'b1;
    done0   = n_done;
    hs0     = n_hs;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      b.idx  = k;
      b.data = model(longint'(a[k]), sh, relu);
      exp_q.push_back(b);
    end
    seen = 1'b0;
    for (int n = 1; n <= 400 && !seen; n++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((n % 4) == 1) || ((n % 4) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        if (n == 2) begin
          start  = 1'b1;
          shamt  = '0;
          acc_in = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
      if (n == 1) check("busy_after_start", busy, 1);
      if (mode == 0) begin
        if (sh > 0 && n == sh) check("no_valid_in_shift", out_valid, 0);
        if (n == sh + 1) check("first_valid_cycle", out_valid, 1);
        if (n == sh + NREG) check("busy_last_beat", busy, 1);
      end
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", busy, 0);
        check("valid_at_done", out_valid, 0);
        if (mode == 0) check("done_cycle", n, sh + NREG + 1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    #1;
    check("done_count", n_done - done0, 1);
    check("handshakes", n_hs - hs0, NREG);
    check("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    int a[NREG];
    int d0;
    int hs0;

    rst_n     = 1'b0;
    start     = 1'b0;
    shamt     = '0;
    relu_en   = 1'b0;
    acc_in    = '0;
    out_ready = 1'b0;

    // Pin the model against hand-computed values.
    check("model_m100_s3", model(-100, 3, 0), -13);
    check("model_1000_s3", model(1000, 3, 0), 125);
    check("model_1000_s2", model(1000, 2, 0), 127);
    check("model_m70000", model(-70000, 0, 0), -128);
    check("model_relu_m5", model(-5, 0, 1), 0);
    check("model_relu_300", model(300, 0, 1), 127);
    check("model_m12345_s31", model(-12345, 31, 0), -1);
    check("model_12345_s31", model(12345, 31, 0), 0);

    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed jobs, issued back to back (each next start lands in the done cycle).
    a = '{100, -1, 0, 127};
    run_job(a, 0, 1'b0, 0, 1'b0);
    a = '{-100, 1000, 0, 0};
    run_job(a, 3, 1'b0, 0, 1'b0);
    a = '{0, 1000, 0, 0};
    run_job(a, 2, 1'b0, 0, 1'b0);
    a = '{-70000, 0, 0, 0};
    run_job(a, 0, 1'b0, 0, 1'b0);
    a = '{-5, 5, -300, 300};
    run_job(a, 0, 1'b1, 0, 1'b0);
    a = '{-1, 12345, -12345, 0};
    run_job(a, 31, 1'b0, 0, 1'b0);

    // Backpressure with a start pulse mid-job that must be ignored.
    a = '{rand_acc(), rand_acc(), rand_acc(), rand_acc()};
    run_job(a, 2, 1'b0, 1, 1'b1);
    d0  = n_done;
    hs0 = n_hs;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("no_second_job_done", n_done - d0, 0);
    check("no_second_job_beats", n_hs - hs0, 0);
    check("idle_busy", busy, 0);

    // Reset during SHIFT discards the job.
    a = '{1000, -1000, 5000, -5000};
    for (int k = 0; k < NREG; k++) acc_in[k*ACC_W +: ACC_W] = ACC_W'(a[k]);
    shamt = 5'd5;
    relu_en = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("no_done_after_rst", n_done - d0, 0);
    check("idle_after_rst", busy, 0);
    a = '{3000, -3000, 64, -64};
    run_job(a, 4, 1'b0, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int sh;
      a  = '{rand_acc(), rand_acc(), rand_acc(), rand_acc()};
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
      run_job(a, sh, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
